tick_scheduler: RTL

- Sequences the free-running base enable from the clock divider into the timing strobes the DCF77 decoder needs: one sample strobe every TICKS_PER_SAMPLE base ticks, and one second strobe every SAMPLES_PER_SEC samples.
- Provides start/stop control and a resync handshake that phase-aligns the second strobe to a detected DCF77 second edge.
- Sits between the divider (tick source) and the pulse-width sampler and decoder.

---
 rtl/tick_sched_pkg.sv | 21 ++
 rtl/mod_counter.sv | 27 ++
 rtl/tick_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/tick_sched_pkg.sv
// Shared state encoding and counter sizing helper for the tick scheduler.
package tick_sched_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_ARM  = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    ARM  = ST_ARM
  } state_t;

  // Bits needed to hold the values 0..n-1.
  function automatic int cnt_w_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up-counter with enable, synchronous clear and a wrap flag that is
// high on the enabled cycle in which the count rolls over to zero.
module mod_counter
  import tick_sched_pkg::*;
#(
  parameter int N = 10,
  parameter int W = cnt_w_for(N)
) (
  input  logic         clock_5,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(N - 1));

  always_ff @(posedge clock_5) begin
    if (!reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Turns the divider's base tick into sample and second strobes, with start/stop
// and a resync handshake. Optional watchdog: define TICK_SCHED_WATCHDOG_EN.
//
// state | meaning
// IDLE  | stopped, counters held at zero, no strobes
// RUN   | counting ticks into sample/second strobes
// ARM   | counting as in RUN, waiting for a sync_edge to realign the second
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int TICKS_PER_SAMPLE = 10,
  parameter int SAMPLES_PER_SEC  = 100,
  parameter int CNT_W            = 8,
  parameter int WD_SECS          = 2
) (
  input  logic             clock_5,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic             resync_req,
  input  logic             sync_edge,
  output logic             resync_ack,
  output logic             sample_en,
  output logic             sec_en,
  output logic [CNT_W-1:0] phase,
  output logic             running,
  output logic             sync_lost
);

  state_t           state;
  logic             counting;
  logic             sync_hit;
  logic             tick_en;
  logic             cnt_clr;
  logic             tick_wrap;
  logic             phase_wrap;
  logic [CNT_W-1:0] tick_cnt;

  assign counting = (state == RUN) || (state == ARM);
  // A sync edge in ARM swallows any tick arriving in the same cycle.
  assign sync_hit = (state == ARM) && sync_edge && !stop;
  assign tick_en  = counting && tick_in && !stop && !sync_hit;
  assign cnt_clr  = !counting || stop || sync_hit;

  mod_counter #(.N(TICKS_PER_SAMPLE), .W(CNT_W)) u_tick_cnt (
    .clock_5 (clock_5),
    .reset   (reset),
    .en      (tick_en),
    .clr     (cnt_clr),
    .count   (tick_cnt),
    .wrap    (tick_wrap)
  );

  mod_counter #(.N(SAMPLES_PER_SEC), .W(CNT_W)) u_phase_cnt (
    .clock_5 (clock_5),
    .reset   (reset),
    .en      (tick_wrap),
    .clr     (cnt_clr),
    .count   (phase),
    .wrap    (phase_wrap)
  );

  assert property (@(posedge clock_5) disable iff (!reset)
    (tick_cnt < CNT_W'(TICKS_PER_SAMPLE)) && (phase < CNT_W'(SAMPLES_PER_SEC)) && (WD_SECS >= 1));

`ifdef TICK_SCHED_WATCHDOG_EN
  localparam int WD_W = cnt_w_for(WD_SECS + 1);
  logic [WD_W-1:0] wd_left;
`else
  assign sync_lost = 1'b0;
`endif

  always_ff @(posedge clock_5) begin
    if (!reset) begin
      state      <= IDLE;
      sample_en  <= 1'b0;
      sec_en     <= 1'b0;
      resync_ack <= 1'b0;
      running    <= 1'b0;
`ifdef TICK_SCHED_WATCHDOG_EN
      sync_lost  <= 1'b0;
      wd_left    <= '0;
`endif
    end else begin
      sample_en  <= 1'b0;
      sec_en     <= 1'b0;
      resync_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
`ifdef TICK_SCHED_WATCHDOG_EN
            sync_lost <= 1'b0;
`endif
          end else begin
            running <= 1'b0;
          end
        end
        RUN, ARM: begin
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (sync_hit) begin
            state      <= RUN;
            sample_en  <= 1'b1;
            sec_en     <= 1'b1;
            resync_ack <= 1'b1;
`ifdef TICK_SCHED_WATCHDOG_EN
            sync_lost  <= 1'b0;
`endif
          end else begin
            sample_en <= tick_wrap;
            sec_en    <= phase_wrap;
            if (state == RUN && resync_req) begin
              state <= ARM;
`ifdef TICK_SCHED_WATCHDOG_EN
              wd_left <= WD_W'(WD_SECS);
`endif
            end else if (state == ARM && !resync_req) begin
              state <= RUN;
`ifdef TICK_SCHED_WATCHDOG_EN
            end else if (state == ARM && phase_wrap) begin
              // Down-count whole seconds spent armed; give up on the last one.
              if (wd_left <= WD_W'(1)) begin
                sync_lost <= 1'b1;
                state     <= RUN;
              end else begin
                wd_left <= wd_left - WD_W'(1);
              end
`endif
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
